bit_deserialise: RTL and testbench



---
 rtl/bit_deserialise_pkg.sv | 13 +
 rtl/bit_deserialise.sv | 114 +++++++++++
 tb/tb_bit_deserialise.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/bit_deserialise_pkg.sv
// Shared constants for the serial link: shift direction codes (common with
// the transmitting shifter) and the receiver's two-state FSM encoding.
package bit_deserialise_pkg;

  localparam int SHIFT_LEFT  = 0;  // MSB first
  localparam int SHIFT_RIGHT = 1;  // LSB first

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/bit_deserialise.sv
// Serial-in, parallel-out receiver with start-marker framing.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a valid bit qualified by frame_start
// SHIFT | assembling a word; bit_count holds the bits accepted so far
//
// A frame_start seen mid-word abandons the partial word (frame_error pulse)
// and the marked bit restarts assembly as bit 0. A marker on the final-bit
// position is treated the same way, so completion never coincides with an
// error.
module bit_deserialise
  import bit_deserialise_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int SHIFT_DIRECTION = 0,
  parameter int CONTINUOUS      = 0,
  parameter int COUNT_WIDTH     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   serial_in,
  input  logic                   serial_valid,
  input  logic                   frame_start,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   data_valid,
  output logic                   frame_error,
  output logic [COUNT_WIDTH-1:0] bit_count
);

  localparam logic [COUNT_WIDTH-1:0] LAST_BIT = COUNT_WIDTH'(DATA_WIDTH - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);

  state_t                 state, state_nxt;
  logic [DATA_WIDTH-1:0]  shift_reg, shift_nxt;
  logic [DATA_WIDTH-1:0]  shifted, loaded;
  logic [DATA_WIDTH-1:0]  data_nxt;
  logic [COUNT_WIDTH-1:0] count_nxt;
  logic                   valid_nxt, error_nxt;

  // Candidate register values: incoming bit shifted onto the partial word,
  // or the incoming bit alone as bit 0 of a fresh word.
  always_comb begin
    if (SHIFT_DIRECTION == SHIFT_RIGHT) begin
      shifted = {serial_in, shift_reg[DATA_WIDTH-1:1]};
      loaded  = {serial_in, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      shifted = {shift_reg[DATA_WIDTH-2:0], serial_in};
      loaded  = {{(DATA_WIDTH-1){1'b0}}, serial_in};
    end
  end

  // Next-state, counter, shift register and output strobes.
  always_comb begin
    state_nxt = state;
    shift_nxt = shift_reg;
    count_nxt = bit_count;
    data_nxt  = data_out;
    valid_nxt = 1'b0;
    error_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (serial_valid && frame_start) begin
          shift_nxt = loaded;
          count_nxt = CNT_ONE;
          state_nxt = SHIFT;
        end
      end

      SHIFT: begin
        if (serial_valid) begin
          if (frame_start) begin
            // count 0 here is a continuous-mode word boundary, not an abort
            error_nxt = (bit_count != '0);
            shift_nxt = loaded;
            count_nxt = CNT_ONE;
          end else if (bit_count == LAST_BIT) begin
            data_nxt  = shifted;
            valid_nxt = 1'b1;
            shift_nxt = '0;
            count_nxt = '0;
            state_nxt = (CONTINUOUS != 0) ? SHIFT : IDLE;
          end else begin
            shift_nxt = shifted;
            count_nxt = bit_count + CNT_ONE;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shift_reg   <= '0;
      bit_count   <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_nxt;
      shift_reg   <= shift_nxt;
      bit_count   <= count_nxt;
      data_out    <= data_nxt;
      data_valid  <= valid_nxt;
      frame_error <= error_nxt;
    end
  end

endmodule

// File: tb/tb_bit_deserialise.sv
// Scoreboard bench: three receivers (MSB-first, LSB-first, MSB-first
// continuous) share one serial stream; expected words are queued as the
// stream is driven and popped whenever a receiver strobes data_valid.
module tb_bit_deserialise;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic serial_in = 1'b0;
  logic serial_valid = 1'b0;
  logic frame_start = 1'b0;

  logic [7:0] dout_m, dout_l, dout_c;
  logic       dv_m, dv_l, dv_c;
  logic       fe_m, fe_l, fe_c;
  logic [3:0] cnt_m, cnt_l, cnt_c;

  int n_vec = 0;
  int n_err = 0;
  int fe_cnt_m = 0, fe_cnt_l = 0, fe_cnt_c = 0;

  logic [7:0] q_m[$];
  logic [7:0] q_l[$];
  logic [7:0] q_c[$];

  always #5 clk = ~clk;

  bit_deserialise #(.DATA_WIDTH(8), .SHIFT_DIRECTION(0), .CONTINUOUS(0), .COUNT_WIDTH(4)) u_msb (
    .clk(clk), .rst(rst), .serial_in(serial_in), .serial_valid(serial_valid),
    .frame_start(frame_start), .data_out(dout_m), .data_valid(dv_m),
    .frame_error(fe_m), .bit_count(cnt_m));

  bit_deserialise #(.DATA_WIDTH(8), .SHIFT_DIRECTION(1), .CONTINUOUS(0), .COUNT_WIDTH(4)) u_lsb (
    .clk(clk), .rst(rst), .serial_in(serial_in), .serial_valid(serial_valid),
    .frame_start(frame_start), .data_out(dout_l), .data_valid(dv_l),
    .frame_error(fe_l), .bit_count(cnt_l));

  bit_deserialise #(.DATA_WIDTH(8), .SHIFT_DIRECTION(0), .CONTINUOUS(1), .COUNT_WIDTH(4)) u_cont (
    .clk(clk), .rst(rst), .serial_in(serial_in), .serial_valid(serial_valid),
    .frame_start(frame_start), .data_out(dout_c), .data_valid(dv_c),
    .frame_error(fe_c), .bit_count(cnt_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; returns at the same point
  // after the edge that sampled the bit.
  task automatic send_bit(input logic b, input logic fs);
    serial_in    = b;
    serial_valid = 1'b1;
    frame_start  = fs;
    @(posedge clk); #1;
    serial_valid = 1'b0;
    frame_start  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic push(input logic [7:0] m, input logic [7:0] l, input logic [7:0] c);
    q_m.push_back(m);
    q_l.push_back(l);
    q_c.push_back(c);
  endtask

  // Word streamed MSB of w first; framed puts frame_start on the first bit.
  task automatic send_word(input logic [7:0] w, input logic framed);
    for (int i = 7; i >= 0; i--) send_bit(w[i], framed && (i == 7));
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (dv_m) begin
        chk("msb_dv_expected", 32'(q_m.size() != 0), 1);
        if (q_m.size() != 0) chk("msb_word", dout_m, q_m.pop_front());
        chk("msb_dv_fe_excl", fe_m, 0);
      end
      if (dv_l) begin
        chk("lsb_dv_expected", 32'(q_l.size() != 0), 1);
        if (q_l.size() != 0) chk("lsb_word", dout_l, q_l.pop_front());
        chk("lsb_dv_fe_excl", fe_l, 0);
      end
      if (dv_c) begin
        chk("cont_dv_expected", 32'(q_c.size() != 0), 1);
        if (q_c.size() != 0) chk("cont_word", dout_c, q_c.pop_front());
        chk("cont_dv_fe_excl", fe_c, 0);
      end
      if (fe_m) fe_cnt_m++;
      if (fe_l) fe_cnt_l++;
      if (fe_c) fe_cnt_c++;
    end
  end

  initial begin
    logic [7:0] w;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", {dout_m, dout_l, dout_c}, 0);
    chk("rst_dv", {dv_m, dv_l, dv_c}, 0);
    chk("rst_fe", {fe_m, fe_l, fe_c}, 0);
    chk("rst_cnt", {cnt_m, cnt_l, cnt_c}, 0);
    rst = 1'b0;
    idle(2);

    // 0,1,0,1,... back to back
    push(8'h55, 8'hAA, 8'h55);
    send_word(8'h55, 1'b1);
    chk("t1_dv_latency", {dv_m, dv_l, dv_c}, 3'b111);
    chk("t1_dout_msb", dout_m, 8'h55);
    chk("t1_cnt_zero", cnt_m, 0);
    idle(1);
    chk("t1_dv_one_cycle", {dv_m, dv_l, dv_c}, 0);
    chk("t1_no_fe", {fe_m, fe_l, fe_c}, 0);
    idle(2);

    // same word with 2-cycle gaps
    push(8'h55, 8'hAA, 8'h55);
    w = 8'h55;
    for (int i = 7; i >= 0; i--) begin
      send_bit(w[i], i == 7);
      if (i == 5) chk("t2_cnt_after3", cnt_m, 3);
      if (i > 0) idle(2);
      if (i == 5) chk("t2_cnt_hold_gap", {cnt_m, cnt_l, cnt_c}, {4'd3, 4'd3, 4'd3});
    end
    idle(2);

    // abort after three bits, restart with 0x0F
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    push(8'h0F, 8'hF0, 8'h0F);
    w = 8'h0F;
    send_bit(w[7], 1'b1);
    chk("t3_fe_pulse", {fe_m, fe_l, fe_c}, 3'b111);
    chk("t3_cnt_restart", {cnt_m, cnt_l, cnt_c}, {4'd1, 4'd1, 4'd1});
    chk("t3_dout_kept", {dout_m, dout_l, dout_c}, {8'h55, 8'hAA, 8'h55});
    chk("t3_no_dv", {dv_m, dv_l, dv_c}, 0);
    for (int i = 6; i >= 0; i--) send_bit(w[i], 1'b0);
    idle(2);

    // one marker then 16 bits: continuous receiver gets both bytes
    push(8'h55, 8'hAA, 8'h55);
    q_c.push_back(8'h0F);
    w = 8'h55;
    for (int i = 7; i >= 0; i--) send_bit(w[i], i == 7);
    chk("t4_cont_dv1", dv_c, 1);
    w = 8'h0F;
    for (int i = 7; i >= 0; i--) begin
      send_bit(w[i], 1'b0);
      if (i == 7) chk("t4_msb_dropped_cnt", cnt_m, 0);
    end
    chk("t4_cont_dv2", dv_c, 1);
    chk("t4_cont_dout2", dout_c, 8'h0F);
    chk("t4_msb_no_dv", {dv_m, dv_l}, 0);
    chk("t4_msb_dout_held", dout_m, 8'h55);
    chk("t4_cnt_end", {cnt_m, cnt_l, cnt_c}, 0);
    idle(2);

    // marker on the final-bit position aborts, then 0x81 restarts there
    for (int i = 0; i < 7; i++) send_bit(1'b1, i == 0);
    chk("t6_cnt_before_last", {cnt_m, cnt_l, cnt_c}, {4'd7, 4'd7, 4'd7});
    push(8'h81, 8'h81, 8'h81);
    w = 8'h81;
    send_bit(w[7], 1'b1);
    chk("t6_abort_fe", {fe_m, fe_l, fe_c}, 3'b111);
    chk("t6_abort_no_dv", {dv_m, dv_l, dv_c}, 0);
    chk("t6_abort_dout", {dout_m, dout_l, dout_c}, {8'h55, 8'hAA, 8'h0F});
    for (int i = 6; i >= 0; i--) send_bit(w[i], 1'b0);
    idle(2);

    // asynchronous reset after five bits
    w = 8'h55;
    for (int i = 7; i >= 3; i--) send_bit(w[i], i == 7);
    chk("t5_cnt_before_rst", cnt_m, 5);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_dout", {dout_m, dout_l, dout_c}, 0);
    chk("t5_async_cnt", {cnt_m, cnt_l, cnt_c}, 0);
    chk("t5_async_flags", {dv_m, dv_l, dv_c, fe_m, fe_l, fe_c}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    push(8'h3A, 8'h5C, 8'h3A);
    send_word(8'h3A, 1'b1);
    chk("t5_after_rst_dout", {dout_m, dout_l, dout_c}, {8'h3A, 8'h5C, 8'h3A});
    idle(3);

    chk("end_q_msb_empty", q_m.size(), 0);
    chk("end_q_lsb_empty", q_l.size(), 0);
    chk("end_q_cont_empty", q_c.size(), 0);
    chk("end_fe_count_msb", fe_cnt_m, 2);
    chk("end_fe_count_lsb", fe_cnt_l, 2);
    chk("end_fe_count_cont", fe_cnt_c, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
